// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch control states
//   NOP_INSTR     : instruction word shown on if_instr while nothing has been fetched
//   INSTR_BYTES   : PC increment per instruction
//   ALIGN_MASK    : clears the byte-offset bits of a PC
//   align_pc()    : word-aligns a PC
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry valid/ready holding register between fetch and decode.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture load_pc/load_instr and mark the entry valid
//   load_pc/instr     : PC and instruction word to capture
//   flush             : drop the entry (redirect); wins over load and pop
//   pop               : decode consumed the entry
//   valid, pc, instr  : held entry
module fetch_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        flush,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next-entry selection; data only changes on load so it stays stable under backpressure.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (pop) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage closing the loop around an enable-less program counter.
// It issues one word-aligned request at a time, buffers the returned word for
// decode and decides every cycle whether the PC holds, increments or redirects.
//   clk, rst                     : clock, asynchronous active-high reset
//   pc_in / pc_next              : current PC from / next PC to program_counter
//   imem_req_valid/ready/addr    : instruction memory request handshake
//   imem_resp_valid/data         : memory response, one per accepted request
//   redirect_valid/pc            : single-cycle branch/jump redirect
//   if_valid/ready/pc/instr      : buffered instruction towards decode
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  pc_next_s;
    logic [31:0]  fetch_pc_s;
    logic         buf_load_s;
    logic         buf_flush_s;
    logic         buf_pop_s;
    logic         buf_valid_s;

    assign fetch_pc_s     = align_pc(pc_in);
    assign imem_req_addr  = fetch_pc_s;
    // State already sits in S_REQ during reset; the request must still be held off.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    // A redirect cycle never hands an instruction to decode.
    assign if_valid       = buf_valid_s && !redirect_valid;
    assign buf_pop_s      = if_valid && if_ready;
    // program_counter loads pc_next on every edge, so reset must steer it directly.
    assign pc_next        = rst ? RESET_PC : pc_next_s;

    // Next-state, kill flag and PC selection; redirect overrides every state.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        pc_next_s   = pc_in;
        buf_load_s  = 1'b0;
        buf_flush_s = 1'b0;
        if (redirect_valid) begin
            pc_next_s   = align_pc(redirect_pc);
            buf_flush_s = 1'b1;
            // A request still in flight after this cycle must have its response dropped.
            if (((state_q == S_REQ) && imem_req_ready) ||
                ((state_q == S_WAIT) && !imem_resp_valid)) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (imem_resp_valid) begin
                        buf_load_s = 1'b1;
                        pc_next_s  = pc_in + INSTR_BYTES;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_OUT: begin
                    if (buf_pop_s) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // State and kill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load_s),
        .load_pc    (fetch_pc_s),
        .load_instr (imem_resp_data),
        .flush      (buf_flush_s),
        .pop        (buf_pop_s),
        .valid      (buf_valid_s),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Integration bench: instr_fetch + a behavioural program counter + a behavioural
// instruction memory with configurable latency and request stalls. A transaction-level
// scoreboard predicts the PC sequence decode must see (sequential, restarting at each
// redirect target or at RESET_PC after reset).
module tb_instr_fetch;

    localparam logic [31:0] MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, pc_next;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_xfer  = 0;
    int          last_xfer_cyc = 0;
    logic [31:0] last_xfer_pc  = 32'h0;
    logic [31:0] exp_pc  = 32'h0;
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = 32'h0;
    bit          prev_if_stall = 1'b0;
    bit          prev_req_stall = 1'b0;
    logic [31:0] prev_if_pc, prev_if_instr, prev_req_addr;

    always #5 clk = ~clk;

    // Behavioural program_counter: loads pc_next on every edge.
    always_ff @(posedge clk) pc_in <= pc_next;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called at posedge+1 with inputs set; samples at negedge.
    task automatic cycle();
        #4;
        if (!rst) begin
            check_eq("req_addr", imem_req_addr, pc_in & MASK);
            if (redirect_valid) begin
                check_eq("redir_mask", 32'(if_valid), 32'd0);
                check_eq("redir_pc", pc_next, redirect_pc & MASK);
            end else if (pc_next !== pc_in) begin
                check_eq("pc_step", pc_next, pc_in + 32'd4);
            end
            if (prev_if_stall && !redirect_valid) begin
                check_eq("if_valid_hold", 32'(if_valid), 32'd1);
                check_eq("if_pc_hold", if_pc, prev_if_pc);
                check_eq("if_instr_hold", if_instr, prev_if_instr);
            end
            if (prev_req_stall && !redirect_valid) begin
                check_eq("req_valid_hold", 32'(imem_req_valid), 32'd1);
                check_eq("req_addr_hold", imem_req_addr, prev_req_addr);
            end
            if (if_valid && if_ready) begin
                check_eq("xfer_pc", if_pc, exp_pc);
                check_eq("xfer_instr", if_instr, mem_word(exp_pc));
                exp_pc        = exp_pc + 32'd4;
                n_xfer++;
                last_xfer_cyc = cyc;
                last_xfer_pc  = if_pc;
            end
            if (redirect_valid) exp_pc = redirect_pc & MASK;
            if (imem_req_valid && imem_req_ready) begin
                check_eq("one_outstanding", 32'(mem_busy), 32'd0);
                mem_busy = 1'b1;
                mem_addr = imem_req_addr;
                mem_cnt  = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 3));
            end
            prev_if_stall  = if_valid && !if_ready && !redirect_valid;
            prev_if_pc     = if_pc;
            prev_if_instr  = if_instr;
            prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_req_addr  = imem_req_addr;
        end else begin
            prev_if_stall  = 1'b0;
            prev_req_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_resp_valid = 1'b0;
        if (mem_busy && !rst) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_addr);
                mem_busy        = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        mem_busy        = 1'b0;
        #1;
        cycle();
        cycle();
        check_eq("rst_pc_next", pc_next, 32'h0);
        check_eq("rst_pc_in", pc_in, 32'h0);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, NOP);
        rst    = 1'b0;
        exp_pc = 32'h0;
    endtask

    task automatic wait_xfer(input int budget);
        int start;
        start = n_xfer;
        for (int i = 0; i < budget && n_xfer == start; i++) cycle();
        if (n_xfer == start) check_eq("xfer_timeout", 32'(n_xfer), 32'(start + 1));
    endtask

    task automatic wait_if_valid(input int budget);
        for (int i = 0; i < budget && !if_valid; i++) cycle();
        check_eq("if_valid_timeout", 32'(if_valid), 32'd1);
    endtask

    initial begin
        int base;
        int start;
        rst = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        #1;

        // Sequential fetch, L=1: transfers at 2,5,8,11 cycles after reset release.
        mem_lat = 1;
        do_reset();
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_xfer(40);
            check_eq("seq_pc", last_xfer_pc, 32'(4 * k));
            check_eq("seq_timing", 32'(last_xfer_cyc - base), 32'(2 + 3 * k));
        end

        // Backpressure with PC 8 buffered.
        do_reset();
        wait_xfer(40);
        wait_xfer(40);
        if_ready = 1'b0;
        wait_if_valid(20);
        check_eq("bp_if_pc", if_pc, 32'h8);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_pc_in", pc_in, 32'hC);
            check_eq("bp_no_req", 32'(imem_req_valid), 32'd0);
            cycle();
        end
        if_ready = 1'b1;
        wait_xfer(40);
        check_eq("bp_release", last_xfer_pc, 32'h8);

        // Request stall at PC 4.
        do_reset();
        wait_xfer(40);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check_eq("stall_addr", imem_req_addr, 32'h4);
            check_eq("stall_pc_next", pc_next, pc_in);
            cycle();
        end
        imem_req_ready = 1'b1;
        wait_xfer(40);
        check_eq("stall_done", last_xfer_pc, 32'h4);

        // Redirect while the PC 4 request is outstanding.
        mem_lat = 3;
        do_reset();
        wait_xfer(40);
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        wait_xfer(40);
        check_eq("redir_wait_pc", last_xfer_pc, 32'h100);

        // Redirect in S_OUT with if_ready=1 (low bits ignored).
        mem_lat = 1;
        if_ready = 1'b0;
        wait_if_valid(20);
        if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        cycle();
        redirect_valid = 1'b0;
        wait_xfer(40);
        check_eq("redir_out_pc", last_xfer_pc, 32'h40);

        // Wrap-around, then asynchronous reset mid-S_WAIT.
        if_ready = 1'b0;
        wait_if_valid(20);
        if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        wait_xfer(40);
        check_eq("wrap_pc", last_xfer_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc_in", pc_in, 32'h0);
        wait_xfer(40);
        wait_xfer(40);
        mem_lat = 3;
        cycle();
        rst = 1'b1;
        #1;
        check_eq("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("arst_if_valid", 32'(if_valid), 32'd0);
        check_eq("arst_if_pc", if_pc, 32'h0);
        check_eq("arst_if_instr", if_instr, NOP);
        check_eq("arst_pc_next", pc_next, 32'h0);
        do_reset();
        wait_xfer(40);
        check_eq("arst_restart", last_xfer_pc, 32'h0);

        // Randomized traffic against the scoreboard.
        mem_lat = 0;
        do_reset();
        start = n_xfer;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 4) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        check_eq("rand_progress", 32'(n_xfer - start > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
